// File: rtl/sram_obi_arbiter.sv
// Round-robin two-master OBI arbiter sharing the SRAM wrapper's single data port.
// Define SRAM_ARB_RANGE_CHECK_EN to reject out-of-range addresses locally with an error response.
module sram_obi_arbiter #(
   parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   input  logic [31:0] m0_addr_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   input  logic [31:0] m1_addr_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        s_req_o,
   output logic [31:0] s_addr_o,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_gnt_i,
   input  logic        s_rvalid_i,
   input  logic [31:0] s_rdata_i,
   output logic [15:0] illegal_cnt_o
);

   typedef enum logic {
      MST_0 = 1'b0,
      MST_1 = 1'b1
   } master_e;

`ifdef SRAM_ARB_RANGE_CHECK_EN
   localparam bit RangeCheckEn = 1'b1;
`else
   localparam bit RangeCheckEn = 1'b0;
`endif

   master_e     last_q, last_d;
   master_e     owner_q, owner_d;
   master_e     winner;
   logic        pend_q, pend_d;
   logic        w_req, w_we;
   logic [31:0] w_addr, w_wdata;
   logic [3:0]  w_be;
   logic        in_range, illegal;
   logic        fwd, hs_fwd, hs_err, hs;
   logic        sram_rsp, err_rsp, rsp_valid;
   logic [31:0] rsp_data;

   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      winner = MST_0;
      if (m0_req_i && m1_req_i) begin
         winner = (last_q == MST_0) ? MST_1 : MST_0;
      end else if (m1_req_i) begin
         winner = MST_1;
      end
   end

   assign w_req   = (winner == MST_1) ? m1_req_i   : m0_req_i;
   assign w_addr  = (winner == MST_1) ? m1_addr_i  : m0_addr_i;
   assign w_we    = (winner == MST_1) ? m1_we_i    : m0_we_i;
   assign w_be    = (winner == MST_1) ? m1_be_i    : m0_be_i;
   assign w_wdata = (winner == MST_1) ? m1_wdata_i : m0_wdata_i;

   // Out-of-range requests never reach the SRAM; the arbiter accepts them itself.
   assign in_range = (w_addr >= SRAM_BASE_ADDR) && (w_addr < SRAM_END_ADDR);
   assign illegal  = RangeCheckEn && !in_range;
   assign fwd      = w_req && !illegal && !rst_i;
   assign hs_fwd   = fwd && s_gnt_i;
   assign hs_err   = w_req && illegal && !rst_i;
   assign hs       = hs_fwd || hs_err;

   assign s_req_o   = fwd;
   assign s_addr_o  = w_addr;
   assign s_we_o    = w_we;
   assign s_be_o    = w_be;
   assign s_wdata_o = w_wdata;

   assign m0_gnt_o = hs && (winner == MST_0);
   assign m1_gnt_o = hs && (winner == MST_1);

   always_comb begin
      last_d  = last_q;
      owner_d = owner_q;
      pend_d  = pend_q;
      if (s_rvalid_i) begin
         pend_d = 1'b0;
      end
      if (hs) begin
         last_d  = winner;
         owner_d = winner;
      end
      if (hs_fwd) begin
         pend_d = 1'b1;
      end
   end

   // NOTE: registers use non-blocking assignments so each one samples pre-edge values of the others.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q  <= MST_1;
         owner_q <= MST_0;
         pend_q  <= 1'b0;
      end else begin
         last_q  <= last_d;
         owner_q <= owner_d;
         pend_q  <= pend_d;
      end
   end

`ifdef SRAM_ARB_RANGE_CHECK_EN
   logic        errresp_q, errresp_d;
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      errresp_d = hs_err;
      cnt_d     = cnt_q;
      if (hs_err && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         errresp_q <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         errresp_q <= errresp_d;
         cnt_q     <= cnt_d;
      end
   end

   assign err_rsp       = errresp_q && !rst_i;
   assign illegal_cnt_o = cnt_q;
`else
   assign err_rsp       = 1'b0;
   assign illegal_cnt_o = 16'd0;
`endif

   // A response belongs to whoever won the handshake one cycle earlier.
   assign sram_rsp  = s_rvalid_i && pend_q && !rst_i;
   assign rsp_valid = sram_rsp || err_rsp;
   assign rsp_data  = err_rsp ? ERR_RDATA : s_rdata_i;

   assign m0_rvalid_o = rsp_valid && (owner_q == MST_0);
   assign m1_rvalid_o = rsp_valid && (owner_q == MST_1);
   assign m0_rdata_o  = m0_rvalid_o ? rsp_data : 32'd0;
   assign m1_rdata_o  = m1_rvalid_o ? rsp_data : 32'd0;
   assign m0_err_o    = m0_rvalid_o && err_rsp;
   assign m1_err_o    = m1_rvalid_o && err_rsp;

   a_rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i) s_rvalid_i |-> pend_q)
      else $error("s_rvalid_i without an outstanding request");

endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Scoreboard bench for sram_obi_arbiter with a one-cycle-latency SRAM model behind the s_* port.
module tb_sram_obi_arbiter;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
`ifdef SRAM_ARB_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [3:0]  m0_be = 4'hF, m1_be = 4'hF;
   logic        s_gnt = 1'b1, s_rvalid = 1'b0;
   logic [31:0] s_rdata = '0;
   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_req_o, s_we_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [3:0]  s_be_o;
   logic [15:0] illegal_cnt_o;

   sram_obi_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
      .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid_o),
      .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
      .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid_o),
      .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
      .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .illegal_cnt_o(illegal_cnt_o)
   );

   typedef struct {
      bit          mst;
      logic [31:0] rdata;
      bit          err;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_mis = 0;

   // SRAM model: words not yet written return an address-derived pattern.
   logic [31:0]    mem [0:16383];
   logic [16383:0] vld = '0;
   logic           bd_we = 1'b0;
   logic [31:0]    bd_addr = '0, bd_data = '0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (vld[a[15:2]]) return mem[a[15:2]];
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
      return res;
   endfunction

   function automatic bit is_illegal(input logic [31:0] a);
      return RC && ((a < 32'h8000_0000) || (a >= 32'h8000_C000));
   endfunction

   always @(posedge clk) begin
      s_rvalid <= s_req_o && s_gnt && !rst;
      if (s_req_o && s_gnt) begin
         s_rdata <= mem_read(s_addr_o);
         if (s_we_o) begin
            mem[s_addr_o[15:2]] <= merge(mem_read(s_addr_o), s_wdata_o, s_be_o);
            vld[s_addr_o[15:2]] <= 1'b1;
         end
      end
      if (bd_we) begin
         mem[bd_addr[15:2]] <= bd_data;
         vld[bd_addr[15:2]] <= 1'b1;
      end
   end

   task automatic push_exp(input bit mst, input logic [31:0] a, input logic we);
      exp_t e;
      e.mst = mst;
      if (is_illegal(a)) begin
         e.rdata = ERR_RDATA; e.err = 1'b1; e.chk_data = 1'b1;
      end else begin
         e.rdata = mem_read(a); e.err = 1'b0; e.chk_data = !we;
      end
      sb.push_back(e);
   endtask

   // Grant observer: every accepted request owes exactly one response.
   always @(negedge clk) begin
      if (m0_gnt_o || m1_gnt_o) begin
         n_vec++;
         if (m0_gnt_o && m1_gnt_o) begin
            n_mis++;
            $display("FAIL one_grant: got m0_gnt=1 m1_gnt=1, expected only one");
         end
      end
      if (m0_gnt_o) push_exp(1'b0, m0_addr, m0_we);
      if (m1_gnt_o) push_exp(1'b1, m1_addr, m1_we);
   end

   exp_t        mon_e;
   logic [31:0] mon_data, mon_other;
   logic        mon_err;

   always @(negedge clk) begin
      if (m0_rvalid_o || m1_rvalid_o) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL rsp_unexpected: got m0_rvalid=%b m1_rvalid=%b, expected none", m0_rvalid_o, m1_rvalid_o);
         end else begin
            mon_e     = sb.pop_front();
            mon_data  = m1_rvalid_o ? m1_rdata_o : m0_rdata_o;
            mon_other = m1_rvalid_o ? m0_rdata_o : m1_rdata_o;
            mon_err   = m1_rvalid_o ? m1_err_o : m0_err_o;
            if ((m0_rvalid_o && m1_rvalid_o) || (m1_rvalid_o != mon_e.mst) || (mon_err != mon_e.err) ||
                (mon_e.chk_data && (mon_data !== mon_e.rdata)) || (mon_other !== 32'd0)) begin
               n_mis++;
               $display("FAIL rsp: got m0_rv=%b m1_rv=%b err=%b rdata=%h other_rdata=%h, expected mst=%0d err=%b rdata=%h",
                        m0_rvalid_o, m1_rvalid_o, mon_err, mon_data, mon_other, mon_e.mst, mon_e.err, mon_e.rdata);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      m0_req = 1'b0;
      m1_req = 1'b0;
      m0_we  = 1'b0;
      m1_we  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      next_cycle();
      next_cycle();
      sb.delete();
      rst = 1'b0;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m0_req = 1'b1; m0_addr = 32'h8000_0000;
      m1_req = 1'b1; m1_addr = 32'h8000_0004;
      bd_we = 1'b1; bd_addr = 32'h8000_0010; bd_data = 32'h1234_5678;
      next_cycle();
      bd_we = 1'b0;
      sample();
      chk("reset_ctrl", {57'd0, s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}, 64'd0);
      chk("reset_rdata", {m0_rdata_o, m1_rdata_o}, 64'd0);
      chk("reset_cnt", {48'd0, illegal_cnt_o}, 64'd0);
      next_cycle();
      idle();
      rst = 1'b0;
   endtask

   task automatic test_solo_read();
      m0_req = 1'b1; m0_addr = 32'h8000_0010; m0_we = 1'b0;
      sample();
      chk("solo_gnt", {62'd0, m0_gnt_o, m1_gnt_o}, 64'b10);
      chk("solo_s_addr", {32'd0, s_addr_o}, {32'd0, 32'h8000_0010});
      next_cycle();
      idle();
      sample();
      chk("solo_rvalid", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'b10);
      chk("solo_rdata", {32'd0, m0_rdata_o}, {32'd0, 32'h1234_5678});
      next_cycle();
   endtask

   task automatic test_tie();
      logic [1:0] exp_g [3];
      exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
      do_reset();
      m0_req = 1'b1; m0_addr = 32'h8000_0040;
      m1_req = 1'b1; m1_addr = 32'h8000_0080;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk($sformatf("tie_gnt%0d", i), {62'd0, m0_gnt_o, m1_gnt_o}, {62'd0, exp_g[i]});
         if (i > 0) chk($sformatf("tie_rv%0d", i), {62'd0, m0_rvalid_o, m1_rvalid_o}, {62'd0, exp_g[i-1]});
         next_cycle();
      end
      idle();
      sample();
      chk("tie_rv3", {62'd0, m0_rvalid_o, m1_rvalid_o}, {62'd0, exp_g[2]});
      next_cycle();
   endtask

   task automatic test_back_to_back_held_loser();
      logic [1:0]  exp_g [6];
      logic [31:0] h_addr [2];
      logic [31:0] h_data [2];
      int k0 = 0;
      int k1 = 0;
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
      exp_g[3] = 2'b10; exp_g[4] = 2'b10; exp_g[5] = 2'b10;
      h_addr[0] = 32'h8000_0300; h_data[0] = 32'hA5A5_0001;
      h_addr[1] = 32'h8000_0304; h_data[1] = 32'hA5A5_0002;
      for (int c = 0; c < 6; c++) begin
         m0_req = (k0 < 4); m0_we = 1'b0; m0_addr = 32'h8000_0100 + 32'(4 * k0);
         m1_req = (k1 < 2); m1_we = 1'b1; m1_be = 4'hF;
         m1_addr = h_addr[k1 % 2]; m1_wdata = h_data[k1 % 2];
         sample();
         chk($sformatf("burst_gnt%0d", c), {62'd0, m0_gnt_o, m1_gnt_o}, {62'd0, exp_g[c]});
         if (m1_gnt_o) begin
            chk($sformatf("held_s_addr%0d", c), {32'd0, s_addr_o}, {32'd0, h_addr[k1 % 2]});
            chk($sformatf("held_s_wdata%0d", c), {31'd0, s_we_o, s_wdata_o}, {31'd0, 1'b1, h_data[k1 % 2]});
         end
         if (m0_gnt_o) k0++;
         if (m1_gnt_o) k1++;
         next_cycle();
      end
      idle();
      sample();
      next_cycle();
   endtask

   task automatic test_illegal();
      m1_req = 1'b1; m1_addr = 32'h0000_1000; m1_we = 1'b0;
      sample();
      chk("illegal_req_gnt", {62'd0, s_req_o, m1_gnt_o}, {62'd0, !RC, 1'b1});
      next_cycle();
      idle();
      sample();
      chk("illegal_rv_err", {61'd0, m0_rvalid_o, m1_rvalid_o, m1_err_o}, {61'd0, 1'b0, 1'b1, RC});
      chk("illegal_rdata", {32'd0, m1_rdata_o}, {32'd0, RC ? ERR_RDATA : mem_read(32'h0000_1000)});
      chk("illegal_cnt", {48'd0, illegal_cnt_o}, {48'd0, RC ? 16'd1 : 16'd0});
      next_cycle();
   endtask

   task automatic test_write_read();
      m1_req = 1'b1; m1_addr = 32'h8000_0200; m1_we = 1'b1; m1_be = 4'hF; m1_wdata = 32'hCAFE_F00D;
      sample();
      chk("wr_gnt", {62'd0, m0_gnt_o, m1_gnt_o}, 64'b01);
      next_cycle();
      idle();
      m0_req = 1'b1; m0_addr = 32'h8000_0200; m0_we = 1'b0;
      sample();
      chk("wr_rsp_rd_gnt", {60'd0, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}, 64'b1001);
      next_cycle();
      idle();
      sample();
      chk("rd_after_wr", {31'd0, m0_err_o, m0_rdata_o}, {31'd0, 1'b0, 32'hCAFE_F00D});
      next_cycle();
   endtask

   task automatic test_reset_mid();
      m0_req = 1'b1; m0_addr = 32'h8000_0400;
      sample();
      chk("mid_gnt_a", {62'd0, m0_gnt_o, m1_gnt_o}, 64'b10);
      next_cycle();
      m0_addr = 32'h8000_0404;
      sample();
      chk("mid_gnt_b", {62'd0, m0_gnt_o, m1_gnt_o}, 64'b10);
      next_cycle();
      rst = 1'b1;
      idle();
      sample();
      chk("mid_rv_in_rst", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd0);
      next_cycle();
      rst = 1'b0;
      sample();
      chk("mid_rv_after_rst", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd0);
      chk("mid_dropped", 64'(sb.size()), 64'd1);
      next_cycle();
      sb.delete();
      m0_req = 1'b1; m0_addr = 32'h8000_0408;
      m1_req = 1'b1; m1_addr = 32'h8000_040C; m1_we = 1'b0;
      sample();
      chk("mid_tie_gnt", {62'd0, m0_gnt_o, m1_gnt_o}, 64'b10);
      next_cycle();
      idle();
      sample();
      next_cycle();
   endtask

   task automatic test_gnt_stall();
      s_gnt = 1'b0;
      m0_req = 1'b1; m0_addr = 32'h8000_0500; m0_we = 1'b0;
      sample();
      chk("stall_gnt", {61'd0, s_req_o, m0_gnt_o, m1_gnt_o}, 64'b100);
      next_cycle();
      s_gnt = 1'b1;
      sample();
      chk("stall_release", {62'd0, m0_gnt_o, m1_gnt_o}, 64'b10);
      next_cycle();
      idle();
      sample();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_solo_read();
      test_tie();
      test_back_to_back_held_loser();
      test_illegal();
      test_write_read();
      test_reset_mid();
      test_gnt_stall();
      repeat (2) next_cycle();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
